// File: rtl/vx_sched_watchdog_pkg.sv
// Shared types and helpers for the warp-scheduler watchdog: error codes,
// barrier FSM states and the error arbitration priority encoder.
package vx_sched_watchdog_pkg;

  localparam int unsigned NUM_ERR = 6;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_SPAWN_MULTI   = 3'd1,
    ERR_BAR_DUP       = 3'd2,
    ERR_BAR_SIZE      = 3'd3,
    ERR_BAR_INACTIVE  = 3'd4,
    ERR_BAR_TIMEOUT   = 3'd5,
    ERR_STALL_TIMEOUT = 3'd6
  } err_code_e;

  typedef enum logic [1:0] {
    BAR_IDLE = 2'd0,
    BAR_WAIT = 2'd1,
    BAR_DONE = 2'd2
  } bar_state_e;

  typedef struct packed {
    logic timeout;
    logic inactive;
    logic size;
    logic dup;
  } bar_err_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit wins; bit i stands for error code i+1.
  function automatic err_code_e prio_encode(input logic [NUM_ERR-1:0] codes);
    err_code_e code;
    logic      found;
    code  = ERR_NONE;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_ERR; i++) begin
      if (codes[i] && !found) begin
        code  = err_code_e'(3'(i + 1));
        found = 1'b1;
      end
    end
    return code;
  endfunction

  function automatic logic bar_hit(input bar_err_t e, input err_code_e c);
    case (c)
      ERR_BAR_DUP:      return e.dup;
      ERR_BAR_SIZE:     return e.size;
      ERR_BAR_INACTIVE: return e.inactive;
      ERR_BAR_TIMEOUT:  return e.timeout;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vx_sched_watchdog_if.sv
// Warp-control command bundle observed by the watchdog.
interface vx_sched_watchdog_if #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4
);
  localparam int unsigned NW_WIDTH = vx_sched_watchdog_pkg::idx_width(NUM_WARPS);
  localparam int unsigned NB_WIDTH = vx_sched_watchdog_pkg::idx_width(NUM_BARRIERS);

  logic                wctl_valid;
  logic                wspawn_valid;
  logic                bar_valid;
  logic [NB_WIDTH-1:0] bar_id;
  logic [NW_WIDTH-1:0] bar_wid;
  logic [NW_WIDTH-1:0] bar_size_m1;

  modport master (
    output wctl_valid, wspawn_valid, bar_valid, bar_id, bar_wid, bar_size_m1
  );

  modport slave (
    input  wctl_valid, wspawn_valid, bar_valid, bar_id, bar_wid, bar_size_m1
  );
endinterface

// File: rtl/vx_sched_watchdog_bar_tracker.sv
// One barrier: tracks arrived warps, participant count and open time, and
// flags duplicate, size-mismatch, inactive-warp and timeout violations.
module vx_sched_watchdog_bar_tracker
  import vx_sched_watchdog_pkg::*;
#(
  parameter  int unsigned NUM_WARPS   = 4,
  parameter  int unsigned BAR_TIMEOUT = 4096,
  localparam int unsigned NW_WIDTH    = idx_width(NUM_WARPS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_arrive,
  input  logic                i_inactive,
  input  logic [NW_WIDTH-1:0] i_wid,
  input  logic [NW_WIDTH-1:0] i_size_m1,
  output bar_err_t            o_err,
  output logic [NW_WIDTH-1:0] o_wid
);

  localparam int unsigned CW = NW_WIDTH + 1;
  localparam int unsigned TW = idx_width(BAR_TIMEOUT);

  bar_state_e           r_state;
  logic [NUM_WARPS-1:0] r_mask;
  logic [CW-1:0]        r_cnt;
  logic [NW_WIDTH-1:0]  r_size;
  logic [TW-1:0]        r_timer;

  logic [NUM_WARPS-1:0] w_onehot;
  logic                 w_in_wait;
  logic                 w_counted;
  logic                 w_complete;
  logic                 w_timeout;

  always_comb begin
    w_onehot        = '0;
    w_onehot[i_wid] = 1'b1;
  end

  assign w_in_wait  = (r_state == BAR_WAIT);
  assign w_counted  = w_in_wait & i_arrive & ~r_mask[i_wid];
  // A completing arrival suppresses a timeout due on the same cycle.
  assign w_complete = w_counted & (r_cnt == {1'b0, r_size});
  assign w_timeout  = i_enable & w_in_wait & (r_timer == TW'(BAR_TIMEOUT - 1)) & ~w_complete;

  always_comb begin
    o_err          = '0;
    o_err.dup      = w_in_wait & i_arrive & r_mask[i_wid];
    o_err.size     = w_in_wait & i_arrive & (i_size_m1 != r_size);
    o_err.inactive = i_arrive & i_inactive;
    o_err.timeout  = w_timeout;
    o_wid          = i_arrive ? i_wid : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= BAR_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_timer <= '0;
    end else if (i_enable) begin
      case (r_state)
        BAR_IDLE: begin
          if (i_arrive) begin
            r_mask  <= w_onehot;
            r_cnt   <= CW'(1);
            r_size  <= i_size_m1;
            r_timer <= '0;
            r_state <= (i_size_m1 == '0) ? BAR_DONE : BAR_WAIT;
          end
        end
        BAR_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (w_counted) begin
            r_mask <= r_mask | w_onehot;
            r_cnt  <= r_cnt + CW'(1);
          end
          if (w_complete) begin
            r_state <= BAR_DONE;
          end else if (w_timeout) begin
            r_state <= BAR_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
          end
        end
        BAR_DONE: begin
          r_state <= BAR_IDLE;
          r_mask  <= '0;
          r_cnt   <= '0;
        end
        default: r_state <= BAR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vx_sched_watchdog.sv
// Passive runtime monitor beside the warp scheduler: checks wspawn legality,
// barrier protocol and per-warp stall duration, reporting registered errors.
module vx_sched_watchdog
  import vx_sched_watchdog_pkg::*;
#(
  parameter  int unsigned NUM_WARPS     = 4,
  parameter  int unsigned NUM_BARRIERS  = 4,
  parameter  int unsigned STALL_TIMEOUT = 1024,
  parameter  int unsigned BAR_TIMEOUT   = 4096,
  parameter  int unsigned ERR_CNT_W     = 16,
  localparam int unsigned NW_WIDTH      = idx_width(NUM_WARPS),
  localparam int unsigned NB_WIDTH      = idx_width(NUM_BARRIERS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  vx_sched_watchdog_if.slave   i_wctl,
  input  logic [NUM_WARPS-1:0] i_active_warps,
  input  logic [NUM_WARPS-1:0] i_stalled_warps,
  input  logic                 i_clear_errs,
  output logic                 o_err_valid,
  output logic [2:0]           o_err_code,
  output logic [NW_WIDTH-1:0]  o_err_wid,
  output logic [NB_WIDTH-1:0]  o_err_bar_id,
  output logic [NUM_ERR-1:0]   o_err_sticky,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam int unsigned SW = $clog2(STALL_TIMEOUT + 1);

  logic                 w_cmd;
  logic                 w_spawn_err;
  logic                 w_arrive;
  logic                 w_inactive;
  bar_err_t             w_bar_err [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  w_bar_wid [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] w_stall_err;
  logic [NUM_ERR-1:0]   w_codes;
  err_code_e            w_code;
  logic [NW_WIDTH-1:0]  w_sel_wid;
  logic [NB_WIDTH-1:0]  w_sel_bid;
  logic                 w_found;

  logic [SW-1:0]        r_stall_cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] r_stall_rep;

  logic                 r_err_valid;
  logic [2:0]           r_err_code;
  logic [NW_WIDTH-1:0]  r_err_wid;
  logic [NB_WIDTH-1:0]  r_err_bar_id;
  logic [NUM_ERR-1:0]   r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_cmd       = i_enable & i_wctl.wctl_valid;
  assign w_spawn_err = w_cmd & i_wctl.wspawn_valid & ($countones(i_active_warps) != 1);
  assign w_arrive    = w_cmd & i_wctl.bar_valid;
  assign w_inactive  = ~i_active_warps[i_wctl.bar_wid];

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_bar
    vx_sched_watchdog_bar_tracker #(
      .NUM_WARPS   (NUM_WARPS),
      .BAR_TIMEOUT (BAR_TIMEOUT)
    ) u_bar (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_arrive   (w_arrive & (i_wctl.bar_id == NB_WIDTH'(b))),
      .i_inactive (w_inactive),
      .i_wid      (i_wctl.bar_wid),
      .i_size_m1  (i_wctl.bar_size_m1),
      .o_err      (w_bar_err[b]),
      .o_wid      (w_bar_wid[b])
    );
  end

  always_comb begin
    w_stall_err = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      w_stall_err[w] = i_enable & (r_stall_cnt[w] == SW'(STALL_TIMEOUT)) & ~r_stall_rep[w];
    end
  end

  // Counter saturates so a long stall reports once; dropping the stall re-arms it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '{default: '0};
      r_stall_rep <= '0;
    end else if (i_enable) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (i_stalled_warps[w]) begin
          if (r_stall_cnt[w] != SW'(STALL_TIMEOUT)) begin
            r_stall_cnt[w] <= r_stall_cnt[w] + SW'(1);
          end
          if (w_stall_err[w]) begin
            r_stall_rep[w] <= 1'b1;
          end
        end else begin
          r_stall_cnt[w] <= '0;
          r_stall_rep[w] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_codes    = '0;
    w_codes[0] = w_spawn_err;
    for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
      w_codes[1] = w_codes[1] | w_bar_err[b].dup;
      w_codes[2] = w_codes[2] | w_bar_err[b].size;
      w_codes[3] = w_codes[3] | w_bar_err[b].inactive;
      w_codes[4] = w_codes[4] | w_bar_err[b].timeout;
    end
    w_codes[5] = |w_stall_err;
  end

  always_comb begin
    w_code    = prio_encode(w_codes);
    w_sel_wid = '0;
    w_sel_bid = '0;
    w_found   = 1'b0;
    case (w_code)
      ERR_BAR_DUP, ERR_BAR_SIZE, ERR_BAR_INACTIVE, ERR_BAR_TIMEOUT: begin
        for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
          if (!w_found && bar_hit(w_bar_err[b], w_code)) begin
            w_found   = 1'b1;
            w_sel_bid = NB_WIDTH'(b);
            w_sel_wid = (w_code == ERR_BAR_TIMEOUT) ? '0 : w_bar_wid[b];
          end
        end
      end
      ERR_STALL_TIMEOUT: begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
          if (!w_found && w_stall_err[w]) begin
            w_found   = 1'b1;
            w_sel_wid = NW_WIDTH'(w);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_valid  <= 1'b0;
      r_err_code   <= '0;
      r_err_wid    <= '0;
      r_err_bar_id <= '0;
      r_err_sticky <= '0;
      r_err_count  <= '0;
    end else begin
      r_err_valid  <= |w_codes;
      r_err_code   <= w_code;
      r_err_wid    <= w_sel_wid;
      r_err_bar_id <= w_sel_bid;
      if (i_clear_errs) begin
        r_err_sticky <= w_codes;
        r_err_count  <= (|w_codes) ? ERR_CNT_W'(1) : '0;
      end else begin
        r_err_sticky <= r_err_sticky | w_codes;
        if ((|w_codes) && (r_err_count != '1)) begin
          r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign o_err_valid  = r_err_valid;
  assign o_err_code   = r_err_code;
  assign o_err_wid    = r_err_wid;
  assign o_err_bar_id = r_err_bar_id;
  assign o_err_sticky = r_err_sticky;
  assign o_err_count  = r_err_count;

endmodule
